// File: rtl/router_read_arbiter.sv
// router_read_arbiter: round-robin, packet-granular drain of three router FIFOs into one tagged byte stream
module router_read_arbiter #(
  parameter int MAX_WAIT = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_chan,
  output logic       parity_err,
  output logic       rd_busy,
  output logic       abort
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(MAX_WAIT - 1);
  typedef enum logic [2:0] {IDLE, HDR, HWAIT, BODY, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] grant, rr, c1, c2, c3, pick, cnt;
  logic [3:0] vld;
  logic [7:0] data_g, acc;
  logic [6:0] rem;
  logic [SW-1:0] stall;
  logic [12:0] fifo_q [2];
  logic [12:0] head;
  logic vld_g, found, rd_active, room, issue, inflight, inf_eop, push, pop, wp, rp;

  function automatic logic [1:0] nxt(input logic [1:0] c);
    return c == 2'd2 ? 2'd0 : c + 2'd1;
  endfunction

  assign vld = {1'b0, vld_out_2, vld_out_1, vld_out_0};
  assign vld_g = vld[grant];
  assign data_g = grant == 2'd2 ? data_out_2 : grant == 2'd1 ? data_out_1 : data_out_0;
  assign c1 = rr;
  assign c2 = nxt(rr);
  assign c3 = nxt(c2);
  assign found = |vld;
  assign pick = vld[c1] ? c1 : vld[c2] ? c2 : c3;
  assign rd_active = state == HDR || state == BODY;
  // a read may only be issued if its byte is guaranteed a buffer slot on arrival
  assign room = ({1'b0, cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  assign issue = rd_active & vld_g & room;
  assign abort = rd_active & ~vld_g & (stall == STALL_LIM);
  assign read_enb_0 = issue & (grant == 2'd0);
  assign read_enb_1 = issue & (grant == 2'd1);
  assign read_enb_2 = issue & (grant == 2'd2);
  assign push = inflight;
  assign head = fifo_q[rp];
  assign out_valid = cnt != 2'd0;
  assign pop = out_valid & out_ready;
  assign {out_data, out_sop, out_eop, out_chan} = out_valid ? head[12:1] : 12'd0;
  assign parity_err = out_valid & head[3] & head[0];
  assign rd_busy = state != IDLE;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = found ? HDR : IDLE;
      HDR:     state_nx = abort ? DONE : issue ? HWAIT : HDR;
      HWAIT:   state_nx = inflight ? BODY : HWAIT;
      BODY:    state_nx = (abort || (issue && rem == 7'd1)) ? DONE : BODY;
      DONE:    state_nx = inflight ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= 2'd0;
      rr <= 2'd0;
      inflight <= 1'b0;
      inf_eop <= 1'b0;
      rem <= 7'd0;
      acc <= 8'd0;
      stall <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      fifo_q[0] <= 13'd0;
      fifo_q[1] <= 13'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) grant <= pick;
      if (state == DONE && !inflight) rr <= nxt(grant);
      inflight <= issue;
      inf_eop <= issue & (state == BODY) & (rem == 7'd1);
      stall <= (issue || !rd_active) ? '0 : (!vld_g ? stall + SW'(1) : stall);
      if (state == HWAIT && inflight) rem <= {1'b0, data_g[7:2]} + 7'd1;
      else if (state == BODY && issue) rem <= rem - 7'd1;
      if (inflight) acc <= state == HWAIT ? data_g : acc ^ data_g;
      if (push) begin
        fifo_q[wp] <= {data_g, state == HWAIT, inf_eop, grant, inf_eop & (|(acc ^ data_g))};
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: doc/router_read_arbiter.md
Name: router_read_arbiter

Overview:
- Output-side read scheduler for the 3x1 router.
- Drains the three router output FIFOs (vld_out_x/data_out_x/read_enb_x) into one shared downstream byte stream.
- Round-robin arbitration at whole-packet granularity; packets are never interleaved.
- Tags packet boundaries and checks parity per packet.

Parameters:
- MAX_WAIT, 24: cycles the granted channel may stall (vld_out low) mid-packet before the packet is aborted. Kept below the router's 30-cycle soft-reset window.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vld_out_0/1/2  in  1  router FIFO x non-empty
- data_out_0/1/2  in  8  router FIFO x read data; valid one cycle after read_enb_x
- read_enb_0/1/2  out  1  read strobe to router FIFO x
- out_ready  in  1  downstream accepts byte
- out_valid  out  1  out_data valid
- out_data  out  8  packet byte
- out_sop  out  1  byte is header
- out_eop  out  1  byte is parity (last byte)
- out_chan  out  2  source channel of byte (0..2)
- parity_err  out  1  valid with out_eop; 1 = XOR of all packet bytes != 0
- rd_busy  out  1  state != IDLE
- abort  out  1  one-cycle pulse when a packet is abandoned

Behaviour:
- Reset: all outputs 0, read_enb_x=0, state IDLE, rr pointer=0, output buffer empty, inflight=0, counters 0.
- Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then 1 parity byte. Total = len+2 bytes.
- Output buffer: 2 entries, each {data, sop, eop, chan, perr}.
  - out_valid = buffer non-empty; head is driven on the out_* ports.
  - Pop when out_valid & out_ready. Push and pop may occur in the same cycle.
- Read latency: read_enb_g asserted in cycle t; data_out_g captured into the buffer at the end of cycle t+1. inflight = 1 during that gap.
- Issue rule: read_enb_g = (state HDR or BODY) & vld_out_g & (count + inflight - pop < 2).
  - At most one read_enb high at any time.
  - read_enb_x is never asserted for a non-granted channel.
- FSM:
  - IDLE: scan vld_out starting at the rr pointer, wrapping 2→0. Register the first set channel as grant, go to HDR. No request: stay.
  - HDR: issue one read (header), go to HWAIT.
  - HWAIT: on header capture, set sop, load rem = len+1 (len=0 gives rem=1), init parity acc = header, go to BODY.
  - BODY: each issue decrements rem. The read issued with rem==1 is tagged eop. When rem reaches 0, go to DONE.
  - DONE: wait inflight==0, set rr pointer = grant+1 (mod 3), go to IDLE. Minimum 1 cycle.
- Parity: acc ^= each captured byte. On the eop byte, perr = (acc ^ byte) != 0, stored with that entry. parity_err = head.perr & head.eop.
- Throughput: with out_ready=1 and vld high, one byte per cycle after the header, plus one bubble for HWAIT.
- Stall timer: in HDR/BODY, counts cycles with vld_out_g=0; clears on any issue.
  - At MAX_WAIT: pulse abort, drop remaining reads, go to DONE.
  - Bytes already buffered still drain; no eop is generated for an aborted packet.
- Backpressure never loses or duplicates bytes: buffer count never exceeds 2.
- Reset mid-packet: next cycle everything returns to reset values; buffered bytes are discarded.

Test Plan:
1. Reset; ch0 packet len=12 (header 0x30), out_ready=1:
   - read_enb_0 1 cycle, 1-cycle bubble, then 13 consecutive cycles.
   - 14 bytes out with out_chan=0: sop on 0x30, eop on parity byte.
   - parity_err=0; rd_busy falls after DONE.
2. Three packets pending at once (len 14 on ch0, 16 on ch1, 17 on ch2):
   - Served in order 0,1,2, no interleaving.
   - A fourth packet on ch0 arriving during ch2 service is served after ch2.
3. len=16 on ch1, out_ready toggling 1/0 every cycle:
   - Output byte sequence equals input sequence.
   - Buffer count ≤2; no read_enb_1 when count+inflight-pop ≥2.
4. len=10 packet on ch2 with random (wrong) parity byte: parity_err=1 coincident only with the out_eop byte.
5. ch1 len=16, vld_out_1 forced low after 5 payload reads for MAX_WAIT=24 cycles:
   - abort pulses once; read_enb_1 stays 0.
   - Buffered bytes drain without eop.
   - Pending ch2 packet then served with sop.
6. reset asserted during BODY of a ch0 packet: next cycle out_valid=0, read_enb_x=0, rd_busy=0, rr pointer=0.
